// File: rtl/spu_issue_pkg.sv
// Shared encodings and filler constants for the dual-pipe issue stage.
// State codes double as protocol codes except EMPTY, which reports PAIR.
package spu_issue_pkg;

   typedef enum logic [1:0] {
      ST_PAIR         = 2'b00,
      ST_SPLIT_FIRST  = 2'b01,
      ST_SPLIT_SECOND = 2'b10,
      ST_EMPTY        = 2'b11
   } issue_state_e;

   localparam logic [0:1] PROTO_PAIR         = 2'b00;
   localparam logic [0:1] PROTO_SPLIT_FIRST  = 2'b01;
   localparam logic [0:1] PROTO_SPLIT_SECOND = 2'b10;

   localparam logic [0:31] NOP_EVEN_DEFAULT = 32'h4020_0000;
   localparam logic [0:31] LNOP_ODD_DEFAULT = 32'h0020_0000;

   function automatic logic [0:1] protocol_of(input issue_state_e s);
      case (s)
         ST_SPLIT_FIRST:  return PROTO_SPLIT_FIRST;
         ST_SPLIT_SECOND: return PROTO_SPLIT_SECOND;
         default:         return PROTO_PAIR;
      endcase
   endfunction

endpackage

// File: rtl/issue_slot_router.sv
// Steers the held instruction pair into even/odd slots from registered state only.
module issue_slot_router
   import spu_issue_pkg::*;
#(
   parameter logic [0:31] NOP_EVEN = NOP_EVEN_DEFAULT,
   parameter logic [0:31] LNOP_ODD = LNOP_ODD_DEFAULT
) (
   input  issue_state_e state,
   input  logic [0:31]  instr1,
   input  logic [0:31]  instr2,
   input  logic         type1,
   input  logic         type2,
   output logic [0:31]  instr_even,
   output logic [0:31]  instr_odd,
   output logic         valid_even,
   output logic         valid_odd,
   output logic [0:1]   protocol
);

   logic place1;
   logic place2;

   always_comb begin
      place1 = 1'b0;
      place2 = 1'b0;
      case (state)
         ST_PAIR: begin
            place1 = 1'b1;
            // same-pipe pair: instr1 owns the slot, instr2 waits for a split
            place2 = (type1 != type2);
         end
         ST_SPLIT_FIRST:  place1 = 1'b1;
         ST_SPLIT_SECOND: place2 = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      instr_even = NOP_EVEN;
      instr_odd  = LNOP_ODD;
      valid_even = 1'b0;
      valid_odd  = 1'b0;
      protocol   = protocol_of(state);
      if (place1) begin
         if (type1) begin
            instr_odd = instr1;
            valid_odd = 1'b1;
         end else begin
            instr_even = instr1;
            valid_even = 1'b1;
         end
      end
      if (place2) begin
         if (type2) begin
            instr_odd = instr2;
            valid_odd = 1'b1;
         end else begin
            instr_even = instr2;
            valid_even = 1'b1;
         end
      end
   end

endmodule

// File: rtl/issue_control.sv
// Dual-issue control: holds one fetched pair, splits dependent pairs over two
// cycles, honours hazard inputs and counts stalled cycles.
module issue_control
   import spu_issue_pkg::*;
#(
   parameter logic [0:31] NOP_EVEN = NOP_EVEN_DEFAULT,
   parameter logic [0:31] LNOP_ODD = LNOP_ODD_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_valid,
   input  logic [0:31] instr1,
   input  logic [0:31] instr2,
   input  logic        type1,
   input  logic        type2,
   output logic        fetch_ready,
   input  logic        stall,
   input  logic        dependent_stall,
   input  logic        flush,
   output logic [0:31] instr_even,
   output logic [0:31] instr_odd,
   output logic        valid_even,
   output logic        valid_odd,
   output logic        issue_fire,
   output logic [0:1]  instr_dependent_protocol,
   output logic        instr1_type,
   output logic        instr2_type,
   output logic [0:15] stall_cycles
);

   issue_state_e state_q, state_d;
   logic [0:31]  instr1_q, instr1_d;
   logic [0:31]  instr2_q, instr2_d;
   logic         type1_q, type1_d;
   logic         type2_q, type2_d;
   logic [0:15]  stall_cnt_q, stall_cnt_d;
   logic         capture;

   always_comb begin
      state_d     = state_q;
      instr1_d    = instr1_q;
      instr2_d    = instr2_q;
      type1_d     = type1_q;
      type2_d     = type2_q;
      stall_cnt_d = stall_cnt_q;
      issue_fire  = 1'b0;
      fetch_ready = 1'b0;
      capture     = 1'b0;

      case (state_q)
         ST_EMPTY: begin
            fetch_ready = 1'b1;
            if (fetch_valid && !flush) begin
               capture = 1'b1;
               state_d = ST_PAIR;
            end
         end
         ST_PAIR: begin
            if (flush) begin
               state_d = ST_EMPTY;
            end else if (stall) begin
               state_d = ST_PAIR;
            end else if (dependent_stall) begin
               state_d = ST_SPLIT_FIRST;
            end else begin
               issue_fire  = 1'b1;
               fetch_ready = 1'b1;
               capture     = fetch_valid;
               state_d     = fetch_valid ? ST_PAIR : ST_EMPTY;
            end
         end
         ST_SPLIT_FIRST: begin
            if (flush) begin
               state_d = ST_EMPTY;
            end else if (!stall) begin
               issue_fire = 1'b1;
               state_d    = ST_SPLIT_SECOND;
            end
         end
         default: begin
            if (flush) begin
               state_d = ST_EMPTY;
            end else if (!stall) begin
               issue_fire  = 1'b1;
               fetch_ready = 1'b1;
               capture     = fetch_valid;
               state_d     = fetch_valid ? ST_PAIR : ST_EMPTY;
            end
         end
      endcase

      if (capture) begin
         instr1_d = instr1;
         instr2_d = instr2;
         type1_d  = type1;
         type2_d  = type2;
      end

      if ((stall || dependent_stall) && (state_q != ST_EMPTY) && !flush
          && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_EMPTY;
         instr1_q    <= '0;
         instr2_q    <= '0;
         type1_q     <= 1'b0;
         type2_q     <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         instr1_q    <= instr1_d;
         instr2_q    <= instr2_d;
         type1_q     <= type1_d;
         type2_q     <= type2_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   issue_slot_router #(
      .NOP_EVEN(NOP_EVEN),
      .LNOP_ODD(LNOP_ODD)
   ) u_router (
      .state      (state_q),
      .instr1     (instr1_q),
      .instr2     (instr2_q),
      .type1      (type1_q),
      .type2      (type2_q),
      .instr_even (instr_even),
      .instr_odd  (instr_odd),
      .valid_even (valid_even),
      .valid_odd  (valid_odd),
      .protocol   (instr_dependent_protocol)
   );

   assign instr1_type  = type1_q;
   assign instr2_type  = type2_q;
   assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_issue_control.sv
// Scoreboard bench for issue_control: stimulus pushes expected per-cycle outputs,
// a negedge monitor pops and compares them.
module tb_issue_control;

   localparam logic [31:0] NE = 32'h4020_0000;
   localparam logic [31:0] NO = 32'h0020_0000;
   localparam logic [31:0] IA = 32'h1111_1111;
   localparam logic [31:0] IB = 32'h2222_2222;
   localparam logic [31:0] IC = 32'h3333_3333;
   localparam logic [31:0] ID = 32'h4444_4444;
   localparam logic [31:0] IE = 32'h5555_5555;
   localparam logic [31:0] IF = 32'h5A5A_5A5A;
   localparam logic [31:0] IG = 32'h6666_6666;
   localparam logic [31:0] IH = 32'h7777_7777;
   localparam logic [31:0] I0 = 32'h1800_0000;
   localparam logic [31:0] I1 = 32'h3400_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        fetch_valid = 1'b0;
   logic [0:31] instr1 = '0;
   logic [0:31] instr2 = '0;
   logic        type1 = 1'b0;
   logic        type2 = 1'b0;
   logic        fetch_ready;
   logic        stall = 1'b0;
   logic        dependent_stall = 1'b0;
   logic        flush = 1'b0;
   logic [0:31] instr_even;
   logic [0:31] instr_odd;
   logic        valid_even;
   logic        valid_odd;
   logic        issue_fire;
   logic [0:1]  instr_dependent_protocol;
   logic        instr1_type;
   logic        instr2_type;
   logic [0:15] stall_cycles;

   issue_control dut (
      .clk                      (clk),
      .reset                    (reset),
      .fetch_valid              (fetch_valid),
      .instr1                   (instr1),
      .instr2                   (instr2),
      .type1                    (type1),
      .type2                    (type2),
      .fetch_ready              (fetch_ready),
      .stall                    (stall),
      .dependent_stall          (dependent_stall),
      .flush                    (flush),
      .instr_even               (instr_even),
      .instr_odd                (instr_odd),
      .valid_even               (valid_even),
      .valid_odd                (valid_odd),
      .issue_fire               (issue_fire),
      .instr_dependent_protocol (instr_dependent_protocol),
      .instr1_type              (instr1_type),
      .instr2_type              (instr2_type),
      .stall_cycles             (stall_cycles)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          id;
      logic [31:0] ie;
      logic [31:0] io;
      logic        ve;
      logic        vo;
      logic        fire;
      logic        rdy;
      logic [1:0]  proto;
      logic        t1;
      logic        t2;
      logic [15:0] sc;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   next_id = 0;
   exp_t e;

   task automatic chk(input int id, input string name, input logic [31:0] act,
                      input logic [31:0] want);
      if (act !== want) begin
         $display("FAIL vec%0d %s: got %h expected %h", id, name, act, want);
         miscompares++;
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         e = sb.pop_front();
         vectors++;
         chk(e.id, "instr_even", 32'(instr_even), e.ie);
         chk(e.id, "instr_odd", 32'(instr_odd), e.io);
         chk(e.id, "valid_even", 32'(valid_even), 32'(e.ve));
         chk(e.id, "valid_odd", 32'(valid_odd), 32'(e.vo));
         chk(e.id, "issue_fire", 32'(issue_fire), 32'(e.fire));
         chk(e.id, "fetch_ready", 32'(fetch_ready), 32'(e.rdy));
         chk(e.id, "protocol", 32'(instr_dependent_protocol), 32'(e.proto));
         chk(e.id, "instr1_type", 32'(instr1_type), 32'(e.t1));
         chk(e.id, "instr2_type", 32'(instr2_type), 32'(e.t2));
         chk(e.id, "stall_cycles", 32'(stall_cycles), 32'(e.sc));
      end
   end

   task automatic drive(input logic r, fv, input logic [31:0] a, b,
                        input logic ta, tb2, st, ds, fl);
      @(posedge clk);
      #1;
      reset           = r;
      fetch_valid     = fv;
      instr1          = a;
      instr2          = b;
      type1           = ta;
      type2           = tb2;
      stall           = st;
      dependent_stall = ds;
      flush           = fl;
   endtask

   task automatic cyc(input logic r, fv, input logic [31:0] a, b,
                      input logic ta, tb2, st, ds, fl,
                      input logic [31:0] xe, xo, input logic xve, xvo, xfire, xrdy,
                      input logic [1:0] xp, input logic xt1, xt2, input logic [15:0] xsc);
      exp_t x;
      drive(r, fv, a, b, ta, tb2, st, ds, fl);
      x.id = next_id; x.ie = xe; x.io = xo; x.ve = xve; x.vo = xvo;
      x.fire = xfire; x.rdy = xrdy; x.proto = xp; x.t1 = xt1; x.t2 = xt2; x.sc = xsc;
      next_id++;
      sb.push_back(x);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      //  r fv  a   b  ta tb st ds fl |  even odd ve vo fi rd pr t1 t2 sc
      cyc(1, 0, 0,  0,  0, 0, 0, 0, 0,   NE, NO, 0, 0, 0, 1, 0, 0, 0, 16'd0);
      cyc(0, 1, I0, I1, 0, 1, 0, 0, 0,   NE, NO, 0, 0, 0, 1, 0, 0, 0, 16'd0);
      cyc(0, 0, 0,  0,  0, 0, 0, 0, 0,   I0, I1, 1, 1, 1, 1, 0, 0, 1, 16'd0);
      cyc(0, 1, IA, IB, 1, 0, 0, 0, 0,   NE, NO, 0, 0, 0, 1, 0, 0, 1, 16'd0);
      cyc(0, 1, IE, IF, 0, 1, 0, 1, 0,   IB, IA, 1, 1, 0, 0, 0, 1, 0, 16'd0);
      cyc(0, 0, 0,  0,  0, 0, 1, 0, 0,   NE, IA, 0, 1, 0, 0, 1, 1, 0, 16'd1);
      cyc(0, 0, 0,  0,  0, 0, 1, 0, 0,   NE, IA, 0, 1, 0, 0, 1, 1, 0, 16'd2);
      cyc(0, 0, 0,  0,  0, 0, 1, 0, 0,   NE, IA, 0, 1, 0, 0, 1, 1, 0, 16'd3);
      cyc(0, 1, IE, IF, 0, 1, 0, 0, 0,   NE, IA, 0, 1, 1, 0, 1, 1, 0, 16'd4);
      cyc(0, 1, IC, ID, 0, 0, 0, 0, 0,   IB, NO, 1, 0, 1, 1, 2, 1, 0, 16'd4);
      cyc(0, 1, IE, IF, 0, 1, 1, 0, 1,   IC, NO, 1, 0, 0, 0, 0, 0, 0, 16'd4);
      cyc(0, 1, IE, IF, 0, 1, 0, 0, 1,   NE, NO, 0, 0, 0, 1, 0, 0, 0, 16'd4);
      cyc(0, 1, IG, IH, 1, 1, 0, 0, 0,   NE, NO, 0, 0, 0, 1, 0, 0, 0, 16'd4);
      cyc(0, 0, 0,  0,  0, 0, 0, 1, 0,   NE, IG, 0, 1, 0, 0, 0, 1, 1, 16'd4);
      cyc(0, 0, 0,  0,  0, 0, 0, 0, 0,   NE, IG, 0, 1, 1, 0, 1, 1, 1, 16'd5);
      cyc(0, 0, 0,  0,  0, 0, 1, 0, 0,   NE, IH, 0, 1, 0, 0, 2, 1, 1, 16'd5);
      // reset raised between edges while held in SPLIT_SECOND
      cyc(1, 0, 0,  0,  0, 0, 0, 0, 0,   NE, NO, 0, 0, 0, 1, 0, 0, 0, 16'd0);
      cyc(0, 1, I0, I1, 0, 1, 0, 0, 0,   NE, NO, 0, 0, 0, 1, 0, 0, 0, 16'd0);
      cyc(0, 0, 0,  0,  0, 0, 1, 0, 0,   I0, I1, 1, 1, 0, 0, 0, 0, 1, 16'd0);
      for (int j = 1; j <= 65533; j++) drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
      cyc(0, 0, 0,  0,  0, 0, 1, 0, 0,   I0, I1, 1, 1, 0, 0, 0, 0, 1, 16'hFFFE);
      for (int j = 0; j < 4; j++)
         cyc(0, 0, 0, 0, 0, 0, 1, 0, 0,  I0, I1, 1, 1, 0, 0, 0, 0, 1, 16'hFFFF);
      cyc(0, 0, 0,  0,  0, 0, 0, 0, 0,   I0, I1, 1, 1, 1, 1, 0, 0, 1, 16'hFFFF);
      cyc(0, 0, 0,  0,  0, 0, 0, 0, 0,   NE, NO, 0, 0, 0, 1, 0, 0, 1, 16'hFFFF);

      @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         $display("FAIL drain: %0d expected entries left, required 0", sb.size());
         miscompares++;
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/issue_control.md
ISSUE_CONTROL -- requirements
Module: issue_control

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge; reset  in  1  asynchronous, active-high.
REQ-002 SHALL have ports: fetch_valid  in  1  pair available; instr1, instr2  in  [0:31]  program-order pair; type1, type2  in  1  pipe of each (0 even, 1 odd); fetch_ready  out  1  pair accepted this cycle.
REQ-003 SHALL have ports: stall, dependent_stall, flush  in  1  from hazard unit, same cycle.
REQ-004 SHALL have ports: instr_even, instr_odd  out  [0:31]  slot contents to decode/RF; valid_even, valid_odd  out  1  slot holds a real instruction; issue_fire  out  1  current slot contents advance this cycle.
REQ-005 SHALL have ports: instr_dependent_protocol  out  [0:1]  issue mode; instr1_type, instr2_type  out  1  registered type1/type2 of held pair.
REQ-006 SHALL have port: stall_cycles  out  [0:15]  saturating count of cycles with stall or dependent_stall asserted.
REQ-007 Parameters: NOP_EVEN, default 32'h40200000, even-pipe filler; LNOP_ODD, default 32'h00200000, odd-pipe filler.

Function
REQ-008 SHALL hold one instruction pair in a register; states EMPTY, PAIR (protocol 00), SPLIT_FIRST (01), SPLIT_SECOND (10); code 11 never driven.
REQ-009 Input priority in non-EMPTY states SHALL be flush > stall > dependent_stall; dependent_stall SHALL be ignored outside PAIR.
REQ-010 EMPTY: fetch_ready=1; fetch_valid captures pair and types, next state PAIR; else stay.
REQ-011 PAIR: flush -> EMPTY; stall -> hold; dependent_stall -> SPLIT_FIRST, no issue; none -> issue_fire=1, capture next pair if fetch_valid (stay PAIR) else EMPTY.
REQ-012 SPLIT_FIRST: flush -> EMPTY; stall -> hold; none -> issue_fire=1, next SPLIT_SECOND.
REQ-013 SPLIT_SECOND: flush -> EMPTY; stall -> hold; none -> issue_fire=1, capture next pair if fetch_valid (PAIR) else EMPTY.
REQ-014 fetch_ready SHALL be combinational: 1 in EMPTY, or in PAIR/SPLIT_SECOND when issue_fire=1; 0 otherwise; no capture when flush=1.
REQ-015 Slot routing: PAIR places instr1 in slot of type1, instr2 in slot of type2; if types equal, instr1 occupies that slot, other slot filler, valid=0.
REQ-016 SPLIT_FIRST drives only instr1 in its slot; SPLIT_SECOND only instr2; other slot filler, valid=0.
REQ-017 EMPTY SHALL drive both fillers, valid_even=valid_odd=0, issue_fire=0, protocol 00.
REQ-018 All outputs except fetch_ready and issue_fire SHALL be functions of registered state only (no combinational path hazard->slot outputs).
REQ-019 stall_cycles SHALL increment when (stall | dependent_stall) & state!=EMPTY & !flush, saturating at 16'hFFFF.
REQ-020 Flush on same cycle as fetch_valid SHALL discard the incoming pair; next pair accepted the following cycle from EMPTY.

Reset
REQ-021 Reset SHALL force state EMPTY, pair register 0, types 0, stall_cycles 0, outputs per REQ-017, immediately and asynchronously, including mid-split.
REQ-022 First capture SHALL occur on first rising edge after reset deasserts.

Structure
REQ-023 Shared package spu_issue_pkg SHALL hold state encoding, protocol codes (00/01/10), NOP_EVEN/LNOP_ODD constants.
REQ-024 One combinational sub-module issue_slot_router SHALL implement REQ-015..017; FSM, pair register, counter in issue_control.

Verification
REQ-025 Reset, fetch_valid=1, instr1=32'h18000000 type1=0, instr2=32'h34000000 type2=1, no hazards -> next cycle PAIR, instr_even=18000000, instr_odd=34000000, both valid, issue_fire=1.
REQ-026 PAIR with dependent_stall=1 one cycle -> SPLIT_FIRST (protocol 01, only instr1 valid), then SPLIT_SECOND (10, only instr2 valid), then EMPTY; stall_cycles=1.
REQ-027 SPLIT_FIRST with stall=1 for 3 cycles -> outputs held unchanged, fetch_ready=0, stall_cycles+=3, then proceeds to SPLIT_SECOND.
REQ-028 PAIR with flush=1 and stall=1 and fetch_valid=1 -> EMPTY next cycle, fillers 40200000/00200000, incoming pair dropped.
REQ-029 Async reset asserted mid SPLIT_SECOND between edges -> outputs fillers, protocol 00, stall_cycles 0 without clock edge.
REQ-030 Preload stall_cycles to 16'hFFFE, hold stall 4 cycles -> count sticks at 16'hFFFF.
